swc_mpm_write_sched: RTL and testbench
======================================

Name: swc_mpm_write_sched

Overview:
Write-side scheduler for the shared multiport packet memory. Each input port buffers one full memory line (g_mem_multiply words) and raises a request; the block grants the single wide SRAM write port to one requester per cycle, round-robin, and generates the line address. Per port it keeps the page/offset pointer, a one-deep next-page prefetch slot and page-end signalling toward the page allocator.

Parameters:
g_num_ports, 11, number of write requesters
g_page_addr_width, 10, page number width
g_page_offset_width, 2, line-offset width; lines per page = 2**g_page_offset_width
g_port_sel_width, 4, width of the granted-port index; 2**g_port_sel_width >= g_num_ports

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
line_rdy_i  in  g_num_ports  port holds one complete line to write
page_load_i  in  g_num_ports  1-cycle strobe: load page_addr_i slice for that port
page_addr_i  in  g_num_ports*g_page_addr_width  page numbers, port p at slice p
grant_o  out  g_num_ports  one-hot 1-cycle grant pulse
mem_we_o  out  1  SRAM line write enable
mem_addr_o  out  g_page_addr_width+g_page_offset_width  line address {page, offset}
mem_sel_o  out  g_port_sel_width  index of granted port (SRAM data mux select)
pageend_o  out  g_num_ports  1-cycle pulse: last line of current page written
page_valid_o  out  g_num_ports  port has a valid current page
stall_o  out  g_num_ports  line_rdy_i high with no valid current page
load_err_o  out  g_num_ports  sticky: page_load with current and next both occupied

Behaviour:
- Reset (rst_i sampled high at clk_i edge): all outputs 0; all pages invalid, offsets 0, RR pointer = g_num_ports-1 (port 0 searched first). Reset mid-operation discards pending grants and pages.
- Eligible[p] = line_rdy_i[p] & cur_valid[p] & ~(grant_o[p] currently high). The mask prevents double grants on the stale request in the cycle after a grant.
- Arbitration: search eligible ports from rr_ptr+1 upward, wrapping modulo g_num_ports. The first hit wins, and rr_ptr takes the winner's index. With no eligible port, rr_ptr holds.
- Latency: request sampled at edge t produces grant_o, mem_we_o, mem_addr_o and mem_sel_o, all registered, valid in cycle t+1 for exactly one cycle. mem_addr_o = {cur_page[p], offset[p]} using pre-increment values.
- After a grant, offset[p] increments. If the written offset was all-ones:
  - pageend_o[p] pulses in the same cycle as the grant and offset wraps to 0.
  - If the next slot is valid, it is promoted to current in the same cycle (no bubble) and the next slot is emptied.
  - Otherwise cur_valid[p] clears.
- page_load_i[p]:
  - Current invalid: the page loads into current and offset resets to 0.
  - Current valid, next empty: the page loads into next.
  - Both occupied, with no page-end promotion in this same cycle: the load is ignored and load_err_o[p] sets. It clears only on reset.
  - Load in the same cycle as a page-end promotion: the promotion is applied first, then the load lands in the now-empty next slot. If current had become invalid, the load goes straight to current.
- stall_o[p] is registered and equals line_rdy_i[p] & ~cur_valid[p].
- page_valid_o mirrors cur_valid.
- Throughput: with one port alone, every other cycle (mask rule). With two or more ports requesting, 1 grant per cycle.

Optional Feature:
SWC_SCHED_STRICT_PRIO_EN:
- Defined: port 0 (CPU/NIC port) has strict priority; it is granted whenever eligible, and rr_ptr is left unchanged by port-0 grants. Ports 1..N-1 round-robin among themselves.
- Undefined: all ports are equal round-robin as above.

Test Plan:
- Load port 0 with page 4, then hold line_rdy_i[0] high for 8 cycles → grants in alternate cycles; mem_addr_o = 4<<2|0..3, then pageend_o[0] on the offset-3 grant and page_valid_o[0]=0; stall_o[0]=1 afterwards.
- Port 0 current page 4 and next page 5 loaded; stream 8 lines → addresses 0x010..0x013 then 0x014..0x017 with no gap cycle at the page boundary; a single pageend_o pulse after line 0x013.
- Ports 0, 3 and 10 all with valid pages and line_rdy_i held high → grant order 0,3,10,0,3,10; mem_sel_o = 0,3,10 in turn.
- Port 2 with current and next occupied receives a third page_load_i → load ignored and load_err_o[2]=1; a page_load in the same cycle as a page-end promotion is accepted and no error is raised.
- rst_i asserted for 1 cycle during a grant burst → the next cycle shows all outputs 0, pages invalid and no grant until a new page_load.
- With SWC_SCHED_STRICT_PRIO_EN defined, ports 0 and 5 continuously ready → port 0 granted every eligible cycle; port 5 is granted only in port 0's masked cycles.

Source files
------------

// File: rtl/swc_mpm_write_sched.sv
// -----------------------------------------------------------------------------
// swc_mpm_write_sched
//   Write-side scheduler for the shared multiport packet memory. Every input
//   port that holds one complete memory line raises line_rdy_i. The block
//   grants the single wide SRAM write port to one of them per cycle in
//   round-robin order. It also generates the {page, offset} line address.
//   For each port it tracks the current page and offset, keeps a one-deep
//   next-page prefetch slot, and signals page end toward the page allocator.
//
//   Optional feature macro: SWC_SCHED_STRICT_PRIO_EN
//     defined   : port 0 has strict priority. The round-robin pointer only
//                 moves on grants to ports 1..N-1.
//     undefined : all ports are equal round-robin participants.
//
// Ports
//   clk_i         system clock
//   rst_i         synchronous reset, active-high
//   line_rdy_i    per port: one complete line is waiting to be written
//   page_load_i   per port: 1-cycle strobe, load that port's page_addr_i slice
//   page_addr_i   page numbers, port p occupies slice p
//   grant_o       one-hot, 1-cycle grant pulse
//   mem_we_o      SRAM line write enable
//   mem_addr_o    SRAM line address {page, offset}
//   mem_sel_o     index of the granted port (SRAM data mux select)
//   pageend_o     per port: last line of the current page written
//   page_valid_o  per port: a current page is held
//   stall_o       per port: line ready but no current page (registered)
//   load_err_o    per port, sticky: page load arrived with both slots full
// -----------------------------------------------------------------------------
module swc_mpm_write_sched #(
  parameter int g_num_ports         = 11,
  parameter int g_page_addr_width   = 10,
  parameter int g_page_offset_width = 2,
  parameter int g_port_sel_width    = 4
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [g_num_ports-1:0]                       line_rdy_i,
  input  logic [g_num_ports-1:0]                       page_load_i,
  input  logic [g_num_ports*g_page_addr_width-1:0]     page_addr_i,
  output logic [g_num_ports-1:0]                       grant_o,
  output logic                                         mem_we_o,
  output logic [g_page_addr_width+g_page_offset_width-1:0] mem_addr_o,
  output logic [g_port_sel_width-1:0]                  mem_sel_o,
  output logic [g_num_ports-1:0]                       pageend_o,
  output logic [g_num_ports-1:0]                       page_valid_o,
  output logic [g_num_ports-1:0]                       stall_o,
  output logic [g_num_ports-1:0]                       load_err_o
);

  localparam int PW = g_page_addr_width;
  localparam int OW = g_page_offset_width;
  localparam int SW = g_port_sel_width;
  localparam int AW = PW + OW;
  localparam logic [SW:0]   LP_N       = (SW+1)'(g_num_ports);
  localparam logic [OW-1:0] LP_OFF_ONE = OW'(1);
`ifdef SWC_SCHED_STRICT_PRIO_EN
  localparam logic [g_num_ports-1:0] LP_PORT0 = g_num_ports'(1);
`endif

  logic [g_num_ports-1:0] r_grant;
  logic                   r_we;
  logic [AW-1:0]          r_addr;
  logic [SW-1:0]          r_sel;
  logic [g_num_ports-1:0] r_stall;
  logic [SW-1:0]          r_rr_ptr;

  logic [g_num_ports-1:0] w_cur_valid;
  logic [g_num_ports-1:0] w_pageend;
  logic [g_num_ports-1:0] w_load_err;
  logic [PW-1:0]          w_cur_page [g_num_ports];
  logic [OW-1:0]          w_offset   [g_num_ports];

  logic [g_num_ports-1:0] w_elig;
  logic [g_num_ports-1:0] w_rr_elig;
  logic                   w_rr_hit;
  logic [SW-1:0]          w_rr_idx;
  logic [SW:0]            w_rr_sum;
  logic                   w_win;
  logic [SW-1:0]          w_win_idx;
  logic                   w_rr_upd;
  logic [g_num_ports-1:0] w_win_oh;

  // A port granted last cycle still shows its stale request, so it is masked.
  assign w_elig = line_rdy_i & w_cur_valid & ~r_grant;

`ifdef SWC_SCHED_STRICT_PRIO_EN
  assign w_rr_elig = w_elig & ~LP_PORT0;
`else
  assign w_rr_elig = w_elig;
`endif

  // Round-robin search starting one past the last winner, wrapping modulo N.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    w_rr_sum = '0;
    for (int i = 1; i <= g_num_ports; i++) begin
      w_rr_sum = {1'b0, r_rr_ptr} + (SW+1)'(i);
      if (w_rr_sum >= LP_N) w_rr_sum = w_rr_sum - LP_N;
      if (!w_rr_hit && w_rr_elig[w_rr_sum[SW-1:0]]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_rr_sum[SW-1:0];
      end
    end
  end

  always_comb begin
`ifdef SWC_SCHED_STRICT_PRIO_EN
    if (w_elig[0]) begin
      w_win     = 1'b1;
      w_win_idx = '0;
      w_rr_upd  = 1'b0;
    end else begin
      w_win     = w_rr_hit;
      w_win_idx = w_rr_idx;
      w_rr_upd  = w_rr_hit;
    end
`else
    w_win     = w_rr_hit;
    w_win_idx = w_rr_idx;
    w_rr_upd  = w_rr_hit;
`endif
  end

  always_comb begin
    w_win_oh = '0;
    if (w_win) w_win_oh[w_win_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_grant  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_sel    <= '0;
      r_stall  <= '0;
      r_rr_ptr <= SW'(g_num_ports - 1);
    end else begin
      r_grant <= w_win_oh;
      r_we    <= w_win;
      r_addr  <= w_win ? {w_cur_page[w_win_idx], w_offset[w_win_idx]} : '0;
      r_sel   <= w_win ? w_win_idx : '0;
      r_stall <= line_rdy_i & ~w_cur_valid;
      if (w_rr_upd) r_rr_ptr <= w_win_idx;
    end
  end

  // Per-port page/offset tracking with one-deep next-page slot.
  for (genvar p = 0; p < g_num_ports; p++) begin : g_port
    logic          r_cv, r_nv, r_pe, r_err;
    logic [PW-1:0] r_cp, r_np;
    logic [OW-1:0] r_off;
    logic          w_cv_d, w_nv_d, w_pe_d, w_err_d;
    logic [PW-1:0] w_cp_d, w_np_d, w_ld_page;
    logic [OW-1:0] w_off_d;

    assign w_ld_page = page_addr_i[p*PW +: PW];

    always_comb begin
      w_cv_d  = r_cv;
      w_nv_d  = r_nv;
      w_cp_d  = r_cp;
      w_np_d  = r_np;
      w_off_d = r_off;
      w_pe_d  = 1'b0;
      w_err_d = r_err;
      // Page-end promotion is resolved before any load in the same cycle.
      if (w_win_oh[p]) begin
        w_off_d = r_off + LP_OFF_ONE;
        if (&r_off) begin
          w_pe_d = 1'b1;
          if (r_nv) begin
            w_cp_d = r_np;
            w_nv_d = 1'b0;
          end else begin
            w_cv_d = 1'b0;
          end
        end
      end
      if (page_load_i[p]) begin
        if (!w_cv_d) begin
          w_cp_d  = w_ld_page;
          w_cv_d  = 1'b1;
          w_off_d = '0;
        end else if (!w_nv_d) begin
          w_np_d = w_ld_page;
          w_nv_d = 1'b1;
        end else begin
          w_err_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cv  <= 1'b0;
        r_nv  <= 1'b0;
        r_off <= '0;
        r_pe  <= 1'b0;
        r_err <= 1'b0;
      end else begin
        r_cv  <= w_cv_d;
        r_nv  <= w_nv_d;
        r_off <= w_off_d;
        r_pe  <= w_pe_d;
        r_err <= w_err_d;
      end
    end

    // Page numbers are qualified by the valid flags and need no reset.
    always_ff @(posedge clk_i) begin
      r_cp <= w_cp_d;
      r_np <= w_np_d;
    end

    assign w_cur_valid[p] = r_cv;
    assign w_cur_page[p]  = r_cp;
    assign w_offset[p]    = r_off;
    assign w_pageend[p]   = r_pe;
    assign w_load_err[p]  = r_err;
  end

  assign grant_o      = r_grant;
  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_sel_o    = r_sel;
  assign pageend_o    = w_pageend;
  assign page_valid_o = w_cur_valid;
  assign stall_o      = r_stall;
  assign load_err_o   = w_load_err;

endmodule

// File: tb/tb_swc_mpm_write_sched.sv
// -----------------------------------------------------------------------------
// tb_swc_mpm_write_sched
//   Directed bench for swc_mpm_write_sched. Expected grants (port, line
//   address, page-end) are queued when stimulus is applied. A monitor pops
//   and compares them whenever mem_we_o is seen. Status outputs are checked
//   inline in the stimulus sequence.
// -----------------------------------------------------------------------------
module tb_swc_mpm_write_sched;

  localparam int NP = 11;
  localparam int PW = 10;
  localparam int OW = 2;
  localparam int SW = 4;
  localparam int AW = PW + OW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     line_rdy;
  logic [NP-1:0]     page_load;
  logic [NP*PW-1:0]  page_addr;
  logic [NP-1:0]     grant;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [SW-1:0]     mem_sel;
  logic [NP-1:0]     pageend;
  logic [NP-1:0]     page_valid;
  logic [NP-1:0]     stall;
  logic [NP-1:0]     load_err;

  swc_mpm_write_sched #(
    .g_num_ports        (NP),
    .g_page_addr_width  (PW),
    .g_page_offset_width(OW),
    .g_port_sel_width   (SW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .line_rdy_i  (line_rdy),
    .page_load_i (page_load),
    .page_addr_i (page_addr),
    .grant_o     (grant),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_sel_o   (mem_sel),
    .pageend_o   (pageend),
    .page_valid_o(page_valid),
    .stall_o     (stall),
    .load_err_o  (load_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [SW-1:0] q_sel  [$];
  logic [AW-1:0] q_addr [$];
  logic          q_pe   [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input int addr, input bit pe);
    q_sel.push_back(SW'(sel));
    q_addr.push_back(AW'(addr));
    q_pe.push_back(pe);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int p, input int page);
    page_load[p] = 1'b1;
    page_addr[p*PW +: PW] = PW'(page);
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  logic [SW-1:0] m_sel;
  logic [AW-1:0] m_addr;
  logic          m_pe;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      chk("sb_has_entry", 32'(q_sel.size() > 0), 32'd1);
      if (q_sel.size() > 0) begin
        m_sel  = q_sel.pop_front();
        m_addr = q_addr.pop_front();
        m_pe   = q_pe.pop_front();
        chk("mem_sel", 32'(mem_sel), 32'(m_sel));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("grant_onehot", 32'(grant), 32'd1 << m_sel);
        chk("pageend", 32'(pageend), m_pe ? (32'd1 << m_sel) : 32'd0);
      end
    end else begin
      chk("idle_grant_pageend", 32'({grant, pageend}), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    line_rdy  = '0;
    page_load = '0;
    page_addr = '0;
    step(); step(); step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_sel", 32'(mem_sel), 32'd0);
    chk("rst_page_valid", 32'(page_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    rst = 1'b0;

    // Single port, one page: grants every other cycle, page end on offset 3.
    load(0, 4);
    step();
    page_load = '0;
    chk("t1_page_valid", 32'(page_valid), 32'h001);
    line_rdy[0] = 1'b1;
    push(0, 12'h010, 0); push(0, 12'h011, 0); push(0, 12'h012, 0); push(0, 12'h013, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_we_pattern", 32'(mem_we), 32'((i % 2 == 0) && (i <= 6)));
      if (i == 6) chk("t1_page_invalid", 32'(page_valid), 32'h000);
      if (i == 7) chk("t1_stall", 32'(stall), 32'h001);
    end
    line_rdy = '0;
    step();
    chk("t1_stall_clear", 32'(stall), 32'h000);

    // Current + next page: no gap at the page boundary.
    load(0, 4);
    step();
    load(0, 5);
    step();
    page_load = '0;
    chk("t2_page_valid", 32'(page_valid), 32'h001);
    line_rdy[0] = 1'b1;
    push(0, 12'h010, 0); push(0, 12'h011, 0); push(0, 12'h012, 0); push(0, 12'h013, 1);
    push(0, 12'h014, 0); push(0, 12'h015, 0); push(0, 12'h016, 0); push(0, 12'h017, 1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("t2_we_pattern", 32'(mem_we), 32'(i % 2 == 0));
    end
    line_rdy = '0;
    step();
    chk("t2_page_invalid", 32'(page_valid), 32'h000);

    // Third load into a full port is ignored and flagged.
    load(2, 8);
    step();
    load(2, 9);
    step();
    load(2, 10);
    step();
    page_load = '0;
    chk("t4_load_err", 32'(load_err), 32'h004);
    chk("t4_page_valid", 32'(page_valid), 32'h004);

    // Load coinciding with page-end promotion is accepted into next.
    load(1, 12);
    step();
    load(1, 13);
    step();
    page_load = '0;
    line_rdy[1] = 1'b1;
    push(1, 12'h030, 0); push(1, 12'h031, 0); push(1, 12'h032, 0); push(1, 12'h033, 1);
    push(1, 12'h034, 0); push(1, 12'h035, 0); push(1, 12'h036, 0); push(1, 12'h037, 1);
    push(1, 12'h038, 0); push(1, 12'h039, 0); push(1, 12'h03A, 0); push(1, 12'h03B, 1);
    for (int i = 0; i < 24; i++) begin
      step();
      chk("t4b_we_pattern", 32'(mem_we), 32'((i % 2 == 0) && (i <= 22)));
      if (i == 5) load(1, 14);
      if (i == 6) begin
        page_load = '0;
        chk("t4b_no_err", 32'(load_err), 32'h004);
        chk("t4b_page_valid", 32'(page_valid), 32'h006);
      end
    end
    line_rdy = '0;
    step();
    chk("t4b_page_done", 32'(page_valid), 32'h004);

    // Reset clears sticky error and pages.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_load_err", 32'(load_err), 32'h000);
    chk("rst2_page_valid", 32'(page_valid), 32'h000);

    // Three requesters: one grant per cycle.
    load(0, 1); load(3, 2); load(10, 3);
    step();
    page_load = '0;
    line_rdy = 11'h409;
`ifdef SWC_SCHED_STRICT_PRIO_EN
    push(0, 12'h004, 0); push(3, 12'h008, 0); push(0, 12'h005, 0);
    push(10, 12'h00C, 0); push(0, 12'h006, 0); push(3, 12'h009, 0);
`else
    push(0, 12'h004, 0); push(3, 12'h008, 0); push(10, 12'h00C, 0);
    push(0, 12'h005, 0); push(3, 12'h009, 0); push(10, 12'h00D, 0);
`endif
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t3_we_every_cycle", 32'(mem_we), 32'd1);
    end

    // Reset in the middle of the burst.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_we", 32'(mem_we), 32'd0);
    chk("t5_addr", 32'(mem_addr), 32'd0);
    chk("t5_sel", 32'(mem_sel), 32'd0);
    chk("t5_pageend", 32'(pageend), 32'd0);
    chk("t5_page_valid", 32'(page_valid), 32'd0);
    chk("t5_stall", 32'(stall), 32'd0);
    chk("t5_load_err", 32'(load_err), 32'd0);
    step();
    chk("t5_no_grant", 32'(mem_we), 32'd0);
    chk("t5_stall_after", 32'(stall), 32'h409);
    step();
    chk("t5_no_grant2", 32'(mem_we), 32'd0);
    load(3, 7);
    push(3, 12'h01C, 0);
    step();
    page_load = '0;
    chk("t5_reload_valid", 32'(page_valid), 32'h008);
    step();
    chk("t5_regrant", 32'(mem_we), 32'd1);
    line_rdy = '0;
    step();
    step();

`ifdef SWC_SCHED_STRICT_PRIO_EN
    // Strict priority: port 0 wins whenever eligible, port 5 fills the gaps.
    load(0, 20); load(5, 21);
    step();
    page_load = '0;
    line_rdy = 11'h021;
    push(0, 12'h050, 0); push(5, 12'h054, 0); push(0, 12'h051, 0); push(5, 12'h055, 0);
    push(0, 12'h052, 0); push(5, 12'h056, 0); push(0, 12'h053, 1); push(5, 12'h057, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_we_every_cycle", 32'(mem_we), 32'd1);
    end
    line_rdy = '0;
    step();
    step();
`endif

    chk("sb_drained", 32'(q_sel.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
